// File: rtl/cla_pipe_accumulator_pkg.sv
// Shared DDSM definitions: default accumulator geometry and the width check used
// at elaboration by the pipelined CLA accumulator.
package cla_pipe_accumulator_pkg;

    localparam int P_DATA_WIDTH_DFLT = 24;
    localparam int P_SEG_WIDTH_DFLT  = 4;

    // A usable geometry has positive widths and whole segments only.
    function automatic bit seg_width_ok(input int data_width, input int seg_width);
        if ((seg_width <= 0) || (data_width <= 0)) begin
            return 1'b0;
        end else begin
            return ((data_width % seg_width) == 0);
        end
    endfunction

endpackage

// File: rtl/cla_pipe_accumulator_segment.sv
// One carry-lookahead segment: generate/propagate per bit, carry chain, sum = p ^ c.
// Purely combinational; the top level registers around it.
module cla_segment
    import cla_pipe_accumulator_pkg::*;
#(
    parameter int P_SEG_WIDTH = P_SEG_WIDTH_DFLT
) (
    input  logic [P_SEG_WIDTH-1:0] a_i,
    input  logic [P_SEG_WIDTH-1:0] b_i,
    input  logic                   cin_i,
    output logic [P_SEG_WIDTH-1:0] sum_o,
    output logic                   cout_o
);

    logic [P_SEG_WIDTH-1:0] g_s;
    logic [P_SEG_WIDTH-1:0] p_s;
    logic [P_SEG_WIDTH:0]   c_s;

    assign g_s = a_i & b_i;
    assign p_s = a_i ^ b_i;

    // Carry chain held in a local variable so the vector has no self-dependence.
    always_comb begin
        logic carry_v;
        carry_v = cin_i;
        c_s     = '0;
        for (int i = 0; i < P_SEG_WIDTH; i++) begin
            c_s[i]  = carry_v;
            carry_v = g_s[i] | (p_s[i] & carry_v);
        end
        c_s[P_SEG_WIDTH] = carry_v;
    end

    assign sum_o  = p_s ^ c_s[P_SEG_WIDTH-1:0];
    assign cout_o = c_s[P_SEG_WIDTH];

endmodule

// File: rtl/cla_pipe_accumulator.sv
// Pipelined carry-lookahead accumulator (DDSM first-order MASH stage): one CLA segment
// per pipeline stage, skewed input slices and de-skewed outputs, one sample per clock.
module cla_pipe_accumulator
    import cla_pipe_accumulator_pkg::*;
#(
    parameter int P_DATA_WIDTH = P_DATA_WIDTH_DFLT,
    parameter int P_SEG_WIDTH  = P_SEG_WIDTH_DFLT
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_valid,
    input  logic [P_DATA_WIDTH-1:0] i_data,
    input  logic                    i_cin,
    output logic                    o_valid,
    output logic [P_DATA_WIDTH-1:0] o_sum,
    output logic                    o_cout
);

    localparam int P_NUM_SEG = P_DATA_WIDTH / P_SEG_WIDTH;

    if (!seg_width_ok(P_DATA_WIDTH, P_SEG_WIDTH)) begin : g_width_check
        $fatal(1, "cla_pipe_accumulator: data width must be a multiple of segment width");
    end

    // vld_s[k] is the sample strobe delayed k cycles; it enables segment k.
    logic [P_NUM_SEG:1]   vld_q;
    logic [P_NUM_SEG:0]   vld_s;
    logic [P_NUM_SEG-1:0] carry_s;

    assign vld_s = {vld_q, i_valid};

    // Valid pipeline shared by the skew lines, segments and deskew lines.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            vld_q <= '0;
        end else begin
            vld_q <= vld_s[P_NUM_SEG-1:0];
        end
    end

    for (genvar k = 0; k < P_NUM_SEG; k++) begin : g_seg
        logic [P_SEG_WIDTH-1:0] b_s;
        logic [P_SEG_WIDTH-1:0] sum_s;
        logic [P_SEG_WIDTH-1:0] acc_q;
        logic [P_SEG_WIDTH-1:0] acc_d;
        logic                   cin_s;
        logic                   cout_s;
        logic                   carry_q;
        logic                   carry_d;

        if (k == 0) begin : g_in0
            assign b_s   = i_data[P_SEG_WIDTH-1:0];
            assign cin_s = i_cin;
        end else begin : g_skew
            logic [P_SEG_WIDTH-1:0] skew_q [1:k];

            // Input slice delay line; each stage advances only with its own strobe.
            always_ff @(posedge i_clk) begin
                if (!i_rst_n) begin
                    for (int j = 1; j <= k; j++) begin
                        skew_q[j] <= '0;
                    end
                end else begin
                    if (vld_s[0]) begin
                        skew_q[1] <= i_data[k*P_SEG_WIDTH +: P_SEG_WIDTH];
                    end
                    for (int j = 2; j <= k; j++) begin
                        if (vld_s[j-1]) begin
                            skew_q[j] <= skew_q[j-1];
                        end
                    end
                end
            end

            assign b_s   = skew_q[k];
            assign cin_s = carry_s[k-1];
        end

        cla_segment #(
            .P_SEG_WIDTH(P_SEG_WIDTH)
        ) u_cla (
            .a_i   (acc_q),
            .b_i   (b_s),
            .cin_i (cin_s),
            .sum_o (sum_s),
            .cout_o(cout_s)
        );

        // A stalled slice keeps both its accumulator bits and its pending carry.
        always_comb begin
            if (vld_s[k]) begin
                acc_d   = sum_s;
                carry_d = cout_s;
            end else begin
                acc_d   = acc_q;
                carry_d = carry_q;
            end
        end

        // Segment accumulator slice and carry register.
        always_ff @(posedge i_clk) begin
            if (!i_rst_n) begin
                acc_q   <= '0;
                carry_q <= 1'b0;
            end else begin
                acc_q   <= acc_d;
                carry_q <= carry_d;
            end
        end

        assign carry_s[k] = carry_q;

        if (k == P_NUM_SEG - 1) begin : g_out
            assign o_sum[k*P_SEG_WIDTH +: P_SEG_WIDTH] = acc_q;
        end else begin : g_deskew
            localparam int P_DLY = P_NUM_SEG - 1 - k;
            logic [P_SEG_WIDTH-1:0] dsk_q [1:P_DLY];

            // Deskew line so every slice of a sample reaches o_sum in the same cycle.
            always_ff @(posedge i_clk) begin
                if (!i_rst_n) begin
                    for (int m = 1; m <= P_DLY; m++) begin
                        dsk_q[m] <= '0;
                    end
                end else begin
                    if (vld_s[k+1]) begin
                        dsk_q[1] <= acc_q;
                    end
                    for (int m = 2; m <= P_DLY; m++) begin
                        if (vld_s[k+m]) begin
                            dsk_q[m] <= dsk_q[m-1];
                        end
                    end
                end
            end

            assign o_sum[k*P_SEG_WIDTH +: P_SEG_WIDTH] = dsk_q[P_DLY];
        end
    end

    assign o_valid = vld_s[P_NUM_SEG];
    assign o_cout  = carry_s[P_NUM_SEG-1];

endmodule
